// File: rtl/bus_responder.sv
// Far-end register-memory responder on the four-phase dual-rail bus.
// Optional illegal-code detection and sticky err port: define BUS_ILLEGAL_CHECK_EN.
module bus_responder #(
  parameter int unsigned INPUT  = 13,
  parameter int unsigned OUTPUT = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [INPUT-1:0][1:0]   in,
  output logic [OUTPUT-1:0][1:0]  out,
  output logic                    busy
`ifdef BUS_ILLEGAL_CHECK_EN
  ,
  output logic                    err
`endif
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, EXEC, RESP, RTZ} state_t;

  state_t                   state_q, state_d;
  logic [INPUT-1:0][1:0]    sync1_q, sync1_d;
  logic [INPUT-1:0][1:0]    sync2_q, sync2_d;
  logic [INPUT-1:0][1:0]    prev_q, prev_d;
  logic [1:0]               fill_q, fill_d;
  logic                     armed_q, armed_d;
  logic                     wr_q, wr_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [OUTPUT-1:0]        wdata_q, wdata_d;
  logic [OUTPUT-1:0][1:0]   out_q, out_d;
  logic [OUTPUT-1:0]        mem_q [DEPTH];
  logic [OUTPUT-1:0]        mem_d [DEPTH];
  logic [OUTPUT-1:0]        resp;

  logic all_valid, all_spacer, prev_spacer;
  logic primed, complete, empty;

  // Sample history only counts once every stage has been reloaded from the
  // live bus after reset; cleared flops would otherwise fake an empty bus.
  assign primed = (fill_q == 2'd3);

  always_comb begin
    all_valid   = 1'b1;
    all_spacer  = 1'b1;
    prev_spacer = 1'b1;
    for (int unsigned i = 0; i < INPUT; i++) begin
      if (sync2_q[i][1] == sync2_q[i][0]) all_valid = 1'b0;
      if (sync2_q[i] != 2'b00)            all_spacer = 1'b0;
      if (prev_q[i] != 2'b00)             prev_spacer = 1'b0;
    end
  end

  assign complete = primed && all_valid && (sync2_q == prev_q);
  assign empty    = primed && all_spacer && prev_spacer;

`ifdef BUS_ILLEGAL_CHECK_EN
  logic err_q, err_d;
  logic illegal;

  always_comb begin
    illegal = 1'b0;
    for (int unsigned i = 0; i < INPUT; i++) begin
      if (sync2_q[i] == 2'b11 && prev_q[i] == 2'b11) illegal = 1'b1;
    end
    illegal = illegal && primed;
  end

  assign err = err_q;
`endif

  always_comb begin
    state_d = state_q;
    sync1_d = in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    fill_d  = primed ? fill_q : fill_q + 2'd1;
    armed_d = armed_q | empty;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    out_d   = out_q;
    mem_d   = mem_q;
    resp    = '0;
`ifdef BUS_ILLEGAL_CHECK_EN
    err_d = err_q | illegal;
    if (illegal && state_q == IDLE) armed_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        out_d = '0;
        if (armed_q && complete) begin
          wr_d = sync2_q[0][1];
          for (int unsigned j = 0; j < ADDR_W; j++) addr_d[j] = sync2_q[1 + j][1];
          for (int unsigned j = 0; j < OUTPUT; j++) wdata_d[j] = sync2_q[ADDR_W + 1 + j][1];
          state_d = EXEC;
        end
      end
      EXEC: begin
        resp = wr_q ? wdata_q : mem_q[addr_q];
        if (wr_q) mem_d[addr_q] = wdata_q;
        for (int unsigned j = 0; j < OUTPUT; j++) out_d[j] = {resp[j], ~resp[j]};
        state_d = RESP;
      end
      RESP: begin
        if (empty) begin
          out_d   = '0;
          state_d = RTZ;
        end
      end
      RTZ: begin
        out_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      fill_q  <= '0;
      armed_q <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      out_q   <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) mem_q[k] <= '0;
`ifdef BUS_ILLEGAL_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      fill_q  <= fill_d;
      armed_q <= armed_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      out_q   <= out_d;
      mem_q   <= mem_d;
`ifdef BUS_ILLEGAL_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign out  = out_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_bus_responder.sv
// Directed scoreboard bench for bus_responder; err checks follow BUS_ILLEGAL_CHECK_EN.
module tb_bus_responder;

  localparam int unsigned INPUT  = 13;
  localparam int unsigned OUTPUT = 8;
  localparam int unsigned ADDR_W = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [INPUT-1:0][1:0]  in;
  logic [OUTPUT-1:0][1:0] out;
  logic                   busy;
`ifdef BUS_ILLEGAL_CHECK_EN
  logic                   err;
`endif

  int        checks = 0;
  int        errors = 0;
  logic [7:0] sb_q [$];
  logic [7:0] exp_mem [16];
  bit         saw_idle;

  bus_responder #(.INPUT(INPUT), .OUTPUT(OUTPUT), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .out   (out),
    .busy  (busy)
`ifdef BUS_ILLEGAL_CHECK_EN
    ,
    .err   (err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [INPUT-1:0][1:0] enc_req(input logic w, input logic [3:0] a,
                                                    input logic [7:0] d);
    logic [INPUT-1:0]       b;
    logic [INPUT-1:0][1:0]  r;
    b = {d, a, w};
    for (int i = 0; i < INPUT; i++) r[i] = b[i] ? 2'b10 : 2'b01;
    return r;
  endfunction

  function automatic logic [OUTPUT-1:0][1:0] enc_out(input logic [7:0] d);
    logic [OUTPUT-1:0][1:0] r;
    for (int i = 0; i < OUTPUT; i++) r[i] = d[i] ? 2'b10 : 2'b01;
    return r;
  endfunction

  function automatic bit out_full(input logic [OUTPUT-1:0][1:0] o);
    for (int i = 0; i < OUTPUT; i++) if (o[i] !== 2'b10 && o[i] !== 2'b01) return 1'b0;
    return 1'b1;
  endfunction

  // Presents a request and waits (bounded) for the full response codeword.
  task automatic do_request(input logic [INPUT-1:0][1:0] req, input logic [7:0] expd,
                            input string tag);
    int   n;
    bit   got;
    bit   partial;
    logic [7:0] e;
    sb_q.push_back(expd);
    in = req;
    n = 0; got = 1'b0; partial = 1'b0; saw_idle = 1'b0;
    while (!got && n < 20) begin
      step();
      n++;
      if (busy === 1'b0) saw_idle = 1'b1;
      if (out !== '0) begin
        if (out_full(out)) got = 1'b1;
        else partial = 1'b1;
      end
    end
    check({tag, " partial"}, partial, 0);
    check({tag, " latency"}, n, 5);
    e = sb_q.pop_front();
    check({tag, " data"}, out, enc_out(e));
    check({tag, " busy"}, busy, 1);
  endtask

  task automatic release_bus(input string tag, input bit need_busy_drop);
    int n;
    int m;
    in = '0;
    n = 0;
    while (out !== '0 && n < 10) begin
      step();
      n++;
    end
    check({tag, " rtz within 4"}, (n <= 4), 1);
    if (need_busy_drop) begin
      m = 0;
      while (busy !== 1'b0 && m < 10) begin
        step();
        m++;
      end
      check({tag, " busy drop"}, busy, 0);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d, input string tag);
    exp_mem[a] = d;
    do_request(enc_req(1'b1, a, d), d, tag);
  endtask

  task automatic rd(input logic [3:0] a, input string tag);
    do_request(enc_req(1'b0, a, 8'h00), exp_mem[a], tag);
  endtask

  initial begin
    logic [INPUT-1:0][1:0] full;
    logic [INPUT-1:0][1:0] cur;
    logic [INPUT-1:0][1:0] bad;
    bit early;
    bit served;

    for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
    reset = 1'b1;
    in = '0;
    repeat (3) step();
    check("reset out", out, 0);
    check("reset busy", busy, 0);
`ifdef BUS_ILLEGAL_CHECK_EN
    check("reset err", err, 0);
`endif
    reset = 1'b0;
    repeat (6) step();

    wr(4'd3, 8'hA5, "wr3");
    release_bus("wr3", 1'b1);
    rd(4'd3, "rd3");
    release_bus("rd3", 1'b1);
    rd(4'd4, "rd4");
    release_bus("rd4", 1'b1);

    // Skewed arrival: one more bit of the request valid each cycle.
    exp_mem[7] = 8'h3C;
    full = enc_req(1'b1, 4'd7, 8'h3C);
    cur = '0;
    early = 1'b0;
    for (int i = 0; i < INPUT - 1; i++) begin
      cur[i] = full[i];
      in = cur;
      step();
      if (busy !== 1'b0 || out !== '0) early = 1'b1;
    end
    check("skew early capture", early, 0);
    do_request(full, 8'h3C, "skew");
    release_bus("skew", 1'b1);
    rd(4'd7, "rd7");
    release_bus("rd7", 1'b1);

    // Back-to-back: second request presented as soon as the first enters RTZ.
    wr(4'd5, 8'h5A, "b2b wr5");
    release_bus("b2b wr5", 1'b0);
    rd(4'd5, "b2b rd5");
    check("b2b idle between", saw_idle, 1);
    release_bus("b2b rd5", 1'b1);

    // Reset while holding a response.
    wr(4'd9, 8'h77, "pre-rst wr9");
    reset = 1'b1;
    step();
    check("midrst out", out, 0);
    check("midrst busy", busy, 0);
    for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
    reset = 1'b0;
    served = 1'b0;
    repeat (12) begin
      step();
      if (busy !== 1'b0 || out !== '0) served = 1'b1;
    end
    check("held req after reset ignored", served, 0);
    release_bus("midrst", 1'b1);
    repeat (4) step();
    rd(4'd5, "rd5 cleared");
    release_bus("rd5 cleared", 1'b1);
    wr(4'd9, 8'h77, "re wr9");
    release_bus("re wr9", 1'b1);
    rd(4'd9, "rd9");
    release_bus("rd9", 1'b1);

    // Illegal 11 code on bit 2.
    wr(4'd5, 8'hC3, "wr5 again");
    release_bus("wr5 again", 1'b1);
    bad = enc_req(1'b1, 4'd6, 8'h99);
    bad[2] = 2'b11;
    in = bad;
    served = 1'b0;
    repeat (12) begin
      step();
      if (busy !== 1'b0 || out !== '0) served = 1'b1;
    end
    check("illegal not served", served, 0);
`ifdef BUS_ILLEGAL_CHECK_EN
    check("illegal err set", err, 1);
`endif
    in = '0;
    repeat (5) step();
    rd(4'd6, "rd6 after illegal");
    release_bus("rd6 after illegal", 1'b1);
    rd(4'd5, "rd5 after illegal");
    release_bus("rd5 after illegal", 1'b1);
`ifdef BUS_ILLEGAL_CHECK_EN
    check("err sticky", err, 1);
    reset = 1'b1;
    step();
    check("err cleared", err, 0);
    reset = 1'b0;
    step();
`endif
    check("scoreboard drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
